pwm_capture: RTL and testbench

- Measures the PWM waveforms produced by the team's timer blocks: period and high time of one square-wave input, in prescaler ticks.
- Same timebase scheme as the generator: a prescaler divides clk, and the measurement counters advance on the prescaler tick.
- Sits on the receive side of a PWM link or loopback. Results go to a consumer through a valid/ready handshake, with sticky overrun and timeout flags.

---
 rtl/pwm_capture.sv | 166 ++++++++++++++++
 tb/tb_pwm_capture.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM period / high-time capture. Counts prescaler ticks between edges of a
// synchronised PWM input and hands the result pair out through valid/ready.
module pwm_capture #(
  parameter int unsigned PRESCALE_TICKS = 600,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             meas_valid,
  input  logic             meas_ready,
  input  logic             clr_flags,
  output logic             overrun,
  output logic             timeout
);

  localparam int unsigned PreW = (PRESCALE_TICKS > 1) ? $clog2(PRESCALE_TICKS) : 1;
  localparam logic [PreW-1:0]  PreMax = PreW'(PRESCALE_TICKS - 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StHigh = 2'd1;
  localparam logic [1:0] StLow  = 2'd2;

  logic             sync1_q, sync2_q, prev_q;
  logic [PreW-1:0]  pre_q, pre_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;

  logic             rise, fall, tick;
  logic             capture, sat;
  logic [CNT_W-1:0] pcnt_inc;

  // Edge detect on the synchronised input.
  always_comb begin
    rise = sync2_q & ~prev_q;
    fall = ~sync2_q & prev_q;
  end

  // Prescaler: restarts on every rise so ticks fall at rise + k*PRESCALE_TICKS.
  // A tick coinciding with a rise closes the old period, not the new one.
  always_comb begin
    tick = (pre_q == PreMax);
    if (rise || tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PreW'(1);
    end
  end

  // Measurement FSM: period and high-time counters, saturation to timeout.
  always_comb begin
    pcnt_inc = pcnt_q + {{(CNT_W-1){1'b0}}, tick};
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    hcnt_d   = hcnt_q;
    capture  = 1'b0;
    sat      = 1'b0;
    case (state_q)
      StIdle: begin
        pcnt_d = '0;
        hcnt_d = '0;
        if (rise) state_d = StHigh;
      end
      StHigh, StLow: begin
        if (tick && (pcnt_q == CntMax)) begin
          sat     = 1'b1;
          state_d = StIdle;
          pcnt_d  = '0;
          hcnt_d  = '0;
        end else if ((state_q == StHigh) && fall) begin
          hcnt_d  = pcnt_inc;
          pcnt_d  = pcnt_inc;
          state_d = StLow;
        end else if ((state_q == StLow) && rise) begin
          capture = 1'b1;
          pcnt_d  = '0;
          state_d = StHigh;
        end else begin
          pcnt_d = pcnt_inc;
        end
      end
      default: begin
        state_d = StIdle;
        pcnt_d  = '0;
        hcnt_d  = '0;
      end
    endcase
  end

  // Output register slot and sticky flags; a set event beats clr_flags.
  always_comb begin
    period_d = period_q;
    high_d   = high_q;
    valid_d  = valid_q;
    if (capture && (!valid_q || meas_ready)) begin
      period_d = pcnt_inc;
      high_d   = hcnt_q;
      valid_d  = 1'b1;
    end else if (valid_q && meas_ready) begin
      valid_d = 1'b0;
    end

    if (capture && valid_q && !meas_ready) begin
      overrun_d = 1'b1;
    end else if (clr_flags) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    if (sat) begin
      timeout_d = 1'b1;
    end else if (clr_flags) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // State update with synchronous reset; synchroniser resets high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      pre_q     <= '0;
      state_q   <= StIdle;
      pcnt_q    <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      sync1_q   <= pwm_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pre_q     <= pre_d;
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign meas_period = period_q;
  assign meas_high   = high_q;
  assign meas_valid  = valid_q;
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: an 8-bit instance for the main function and
// a 4-bit instance for counter saturation, both fed the same PWM input.
module tb_pwm_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, pwm_in, meas_ready, clr_flags;
  logic [7:0] a_period, a_high;
  logic       a_valid, a_overrun, a_timeout;
  logic [3:0] b_period, b_high;
  logic       b_valid, b_overrun, b_timeout;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  int pulse_cnt = 0;

  pwm_capture #(.PRESCALE_TICKS(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .meas_period(a_period), .meas_high(a_high), .meas_valid(a_valid),
    .meas_ready(meas_ready), .clr_flags(clr_flags),
    .overrun(a_overrun), .timeout(a_timeout)
  );

  pwm_capture #(.PRESCALE_TICKS(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .meas_period(b_period), .meas_high(b_high), .meas_valid(b_valid),
    .meas_ready(meas_ready), .clr_flags(clr_flags),
    .overrun(b_overrun), .timeout(b_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (mon_en && a_valid) begin
        pulse_cnt++;
        check_eq("t1_period", {24'd0, a_period}, 32'd10);
        check_eq("t1_high", {24'd0, a_high}, 32'd3);
      end
    end
  endtask

  task automatic pwm_period(input int h, input int l);
    pwm_in = 1'b1;
    step(h);
    pwm_in = 1'b0;
    step(l);
  endtask

  initial begin
    reset = 1'b1; pwm_in = 1'b0; meas_ready = 1'b1; clr_flags = 1'b0;
    step(2);

    // Reset state
    check_eq("rst_period", {24'd0, a_period}, 0);
    check_eq("rst_high", {24'd0, a_high}, 0);
    check_eq("rst_valid", {31'd0, a_valid}, 0);
    check_eq("rst_overrun", {31'd0, a_overrun}, 0);
    check_eq("rst_timeout", {31'd0, a_timeout}, 0);

    // 1: steady 12/28 stream, ready=1 -> one 10/3 pulse per period after arming
    reset = 1'b0;
    step(4);
    mon_en = 1'b1;
    repeat (4) pwm_period(12, 28);
    pwm_in = 1'b1;
    step(8);
    mon_en = 1'b0;
    check_eq("t1_pulses", pulse_cnt, 4);
    check_eq("t1_overrun", {31'd0, a_overrun}, 0);

    // 2: ready=0 -> hold first result, overrun on second, reload after drain
    reset = 1'b1; pwm_in = 1'b0; meas_ready = 1'b0;
    step(2);
    reset = 1'b0;
    step(4);
    pwm_period(12, 28);
    pwm_in = 1'b1;
    step(3);
    check_eq("t2_valid1", {31'd0, a_valid}, 1);
    check_eq("t2_period1", {24'd0, a_period}, 10);
    check_eq("t2_high1", {24'd0, a_high}, 3);
    check_eq("t2_ovr_pre", {31'd0, a_overrun}, 0);
    step(13);
    pwm_in = 1'b0;
    step(24);
    pwm_in = 1'b1;
    step(3);
    check_eq("t2_ovr", {31'd0, a_overrun}, 1);
    check_eq("t2_valid_hold", {31'd0, a_valid}, 1);
    check_eq("t2_period_hold", {24'd0, a_period}, 10);
    check_eq("t2_high_hold", {24'd0, a_high}, 3);
    step(17);
    pwm_in = 1'b0;
    step(10);
    meas_ready = 1'b1;
    step(1);
    meas_ready = 1'b0;
    check_eq("t2_drain", {31'd0, a_valid}, 0);
    step(9);
    pwm_in = 1'b1;
    step(3);
    check_eq("t2_valid2", {31'd0, a_valid}, 1);
    check_eq("t2_period2", {24'd0, a_period}, 10);
    check_eq("t2_high2", {24'd0, a_high}, 5);

    // 3: 4-bit counter, input stuck low after arming -> timeout at 16th tick
    reset = 1'b1; pwm_in = 1'b0; meas_ready = 1'b1;
    step(2);
    reset = 1'b0;
    step(4);
    pwm_in = 1'b1;
    step(12);
    pwm_in = 1'b0;
    step(54);
    check_eq("t3_to_early", {31'd0, b_timeout}, 0);
    step(1);
    check_eq("t3_to_set", {31'd0, b_timeout}, 1);
    check_eq("t3_valid", {31'd0, b_valid}, 0);
    step(20);
    pwm_period(12, 28);
    pwm_in = 1'b1;
    step(3);
    check_eq("t3_valid_re", {31'd0, b_valid}, 1);
    check_eq("t3_period_re", {28'd0, b_period}, 10);
    check_eq("t3_high_re", {28'd0, b_high}, 3);
    check_eq("t3_to_sticky", {31'd0, b_timeout}, 1);
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    check_eq("t3_to_clr", {31'd0, b_timeout}, 0);

    // 4: input high through reset -> no false edge, first result 10/3
    reset = 1'b1; pwm_in = 1'b1; meas_ready = 1'b0;
    step(2);
    reset = 1'b0;
    step(10);
    check_eq("t4_no_cap0", {31'd0, a_valid}, 0);
    pwm_in = 1'b0;
    step(8);
    pwm_period(12, 28);
    check_eq("t4_no_cap1", {31'd0, a_valid}, 0);
    pwm_in = 1'b1;
    step(3);
    check_eq("t4_valid", {31'd0, a_valid}, 1);
    check_eq("t4_period", {24'd0, a_period}, 10);
    check_eq("t4_high", {24'd0, a_high}, 3);

    // 5: clr_flags coinciding with an overrun event -> set wins
    step(9);
    pwm_in = 1'b0;
    step(28);
    check_eq("t5_ovr_pre", {31'd0, a_overrun}, 0);
    pwm_in = 1'b1;
    step(2);
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    check_eq("t5_ovr_win", {31'd0, a_overrun}, 1);
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    check_eq("t5_ovr_clr", {31'd0, a_overrun}, 0);
    check_eq("t5_to_clr", {31'd0, a_timeout}, 0);

    // 6: reset mid-HIGH with a pending result
    check_eq("t6_valid_pre", {31'd0, a_valid}, 1);
    reset = 1'b1;
    step(1);
    check_eq("t6_period", {24'd0, a_period}, 0);
    check_eq("t6_high", {24'd0, a_high}, 0);
    check_eq("t6_valid", {31'd0, a_valid}, 0);
    check_eq("t6_overrun", {31'd0, a_overrun}, 0);
    check_eq("t6_timeout", {31'd0, a_timeout}, 0);
    reset = 1'b0;
    step(8);
    pwm_in = 1'b0;
    step(28);
    pwm_period(12, 28);
    pwm_in = 1'b1;
    step(3);
    check_eq("t6_valid_re", {31'd0, a_valid}, 1);
    check_eq("t6_period_re", {24'd0, a_period}, 10);
    check_eq("t6_high_re", {24'd0, a_high}, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
